fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle fetch controller that owns the architectural program counter. It sequences one instruction at a time through four steps: request to instruction memory, response capture, hand-off to the decode/execute stage, and PC update. On retirement it loads the PC from the combinational next-PC datapath (`PC_update`, whose `pc_address` input is driven by `inst_pc`). It sits between the instruction memory port and the core datapath, replacing the free-running PC register of the single-cycle core.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `next_pc`  in  32  target from `PC_update` for the instruction currently presented on `inst_pc`.
- `stall_fetch`  in  1  holds off new memory requests while high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address; always equals the PC register.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_resp_valid`  in  1  read data valid.
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  instruction presented to the datapath.
- `inst`  out  32  registered instruction word.
- `inst_pc`  out  32  PC of the presented instruction; equals the PC register.
- `inst_ready`  in  1  datapath retires the presented instruction.
- `fault`  out  1  sticky misaligned-target fault.
- `retired`  out  32  count of retired instructions.

## Operation
- State register with states REQ, WAIT, ISSUE, FAULT.
- **REQ**
  - `imem_req_valid` = !`stall_fetch`.
  - Transition to WAIT when `imem_req_valid` & `imem_req_ready`.
- **WAIT**
  - No outputs valid.
  - On `imem_resp_valid`: `inst` <= `imem_resp_data`, go to ISSUE.
- **ISSUE**
  - `inst_valid` = 1.
  - On `inst_ready`:
    - PC <= `next_pc`.
    - `retired` <= `retired` + 1, modulo 2^32; 32'hFFFFFFFF wraps to 0.
    - Go to REQ if `next_pc[1:0]` == 2'b00, else go to FAULT.
- **FAULT**
  - `fault` = 1; all valids 0.
  - PC holds the misaligned value for debug.
  - Only `rst` exits this state.
- Ignored inputs:
  - `imem_resp_valid` outside WAIT (no capture).
  - `inst_ready` outside ISSUE.
  - `imem_req_ready` when `imem_req_valid` = 0.
- Only one request is ever outstanding; the next request is issued only after the previous instruction retires.
- The PC is arithmetic-free: all target computation, including 32-bit wrap (32'hFFFFFFFC + 4 = 0), is done by `PC_update`. The PC loads `next_pc` verbatim.
- `stall_fetch` affects REQ only. It never cancels an accepted request or a presented instruction.

## Timing
- Reset values (asynchronous, immediate on `rst` assertion, in any state including mid-request):
  - state = REQ, PC = `RESET_PC`.
  - `inst` = 32'h00000013 (NOP).
  - `retired` = 0, `fault` = 0, `inst_valid` = 0.
  - `imem_req_valid` = !`stall_fetch` (combinational from state).
  - An in-flight memory response arriving after reset is discarded because state is REQ.
- All outputs are Moore, decoded from state/registers, except `imem_req_valid`, which also gates on `stall_fetch`.
- Best-case latency, with `imem_req_ready` high in REQ and `imem_resp_valid` in the first WAIT cycle:
  - request at cycle N.
  - `inst_valid` at N+2.
  - retire at N+2 if `inst_ready`.
  - next request at N+3.
  - Throughput: 1 instruction / 3 cycles.
- Each extra cycle of `imem_req_ready` low, `imem_resp_valid` low, or `inst_ready` low adds exactly one cycle.
- Handshakes complete on the clock edge where valid & ready are both high.
- `inst` and `inst_pc` are stable for the whole of ISSUE.

## Test plan
- **Reset/first fetch:** `RESET_PC` = 0, ready=1, resp next cycle with 32'h00500093, `inst_ready`=1, `next_pc`=4 → request addr 0 at cycle 0, `inst_valid` at cycle 2 with `inst_pc`=0, request addr 4 at cycle 3, `retired`=1.
- **Backpressure:** `imem_req_ready` low 2 cycles, resp delayed 3 cycles, `inst_ready` low 1 cycle → `inst_valid` rises at cycle 2+2+3 = 7, retires at cycle 8, `imem_req_addr` and `inst` stable throughout.
- **Redirect via `PC_update`:**
  - JAL at pc 32'h80 with imm 32'h100 → next request addr 32'h180.
  - JALR with rs1 32'h2000 and imm -16 → next request addr 32'h1FF0.
- **Wrap:** PC 32'hFFFFFFFC sequential retire → next request addr 0, no fault.
- **Fault:** `next_pc`=32'h1002 at retire → `fault`=1, `imem_req_valid`=0 forever. `rst` then returns to REQ at `RESET_PC` with `fault`=0 and `retired`=0.
- **Async reset and stall:**
  - Assert `rst` mid-WAIT; a later `imem_resp_valid` is ignored and the first `inst` is the post-reset fetch.
  - `stall_fetch`=1 in REQ for 4 cycles → `imem_req_valid`=0 for 4 cycles, then the request issues.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Multi-cycle fetch controller that owns the architectural program counter.
// Each instruction goes through a memory request, response capture, hand-off
// to the datapath and a PC load from the external next-PC datapath.
//
// State table:
//   S_REQ   | issue fetch request at pc_q (held off by stall_fetch)
//   S_WAIT  | request accepted, waiting for the instruction word
//   S_ISSUE | instruction presented to the datapath until inst_ready
//   S_FAULT | retired to a misaligned target; sticky until rst
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   next_pc           target computed for the presented instruction
//   stall_fetch       holds off new requests while high
//   imem_req_*        instruction memory request channel
//   imem_resp_*       instruction memory response channel
//   inst_valid/inst/inst_pc/inst_ready   datapath hand-off
//   fault             sticky misaligned-target fault
//   retired           count of retired instructions (wraps at 2^32)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        stall_fetch,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault,
    output logic [31:0] retired
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        case (state_q)
            S_REQ: begin
                if (!stall_fetch && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (inst_ready) begin
                    // PC takes the target verbatim; a misaligned target is
                    // kept in the PC so it can be inspected after the fault.
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = (next_pc[1:0] == 2'b00) ? S_REQ : S_FAULT;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign imem_req_valid = (state_q == S_REQ) && !stall_fetch;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_ISSUE);
    assign inst           = inst_q;
    assign inst_pc        = pc_q;
    assign fault          = (state_q == S_FAULT);
    assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        stall_fetch;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fault;
    logic [31:0] retired;

    fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .next_pc         (next_pc),
        .stall_fetch     (stall_fetch),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .fault           (fault),
        .retired         (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } sb_t;

    sb_t         inst_sb[$];
    logic [31:0] addr_q[$];
    logic [31:0] exp_retired;
    int          n_err = 0;
    int          n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Small next-PC model: 0 = sequential, 1 = JAL (pc+imm), 2 = JALR ((rs1+imm) & ~1).
    function automatic logic [31:0] pc_model(input int kind, input logic [31:0] pc,
                                             input logic [31:0] rs1, input logic [31:0] imm);
        case (kind)
            1:       return pc + imm;
            2:       return (rs1 + imm) & ~32'd1;
            default: return pc + 32'd4;
        endcase
    endfunction

    // One full fetch/issue/retire with given extra wait cycles on each handshake.
    task automatic fetch(input int req_lo, input int resp_lo, input int rdy_lo,
                         input logic [31:0] data, input logic [31:0] npc);
        logic [31:0] exp_addr;
        sb_t         e;
        int          n;
        int          t_req;
        if (addr_q.size() == 0) begin
            chk("addr_q_empty", 32'd1, 32'd0);
            return;
        end
        exp_addr = addr_q.pop_front();
        n = 0;
        imem_req_ready = 1'b0;
        #1;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        if (!imem_req_valid) return;
        chk("req_addr", imem_req_addr, exp_addr);
        t_req = cyc;
        repeat (req_lo) begin
            @(negedge clk);
            chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("req_hold_addr", imem_req_addr, exp_addr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (resp_lo) begin
            chk("wait_inst_valid", 32'(inst_valid), 32'd0);
            chk("wait_addr", imem_req_addr, exp_addr);
            @(negedge clk);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        inst_sb.push_back('{pc: exp_addr, data: data});
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
        chk("issue_valid", 32'(inst_valid), 32'd1);
        chk("issue_latency", 32'(cyc - t_req), 32'(2 + req_lo + resp_lo));
        e = inst_sb.pop_front();
        chk("inst", inst, e.data);
        chk("inst_pc", inst_pc, e.pc);
        repeat (rdy_lo) begin
            @(negedge clk);
            chk("issue_hold_valid", 32'(inst_valid), 32'd1);
            chk("issue_hold_inst", inst, e.data);
            chk("issue_hold_pc", inst_pc, e.pc);
        end
        next_pc    = npc;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready  = 1'b0;
        exp_retired = exp_retired + 32'd1;
        chk("retired", retired, exp_retired);
        chk("retire_latency", 32'(cyc - t_req), 32'(3 + req_lo + resp_lo + rdy_lo));
        chk("pc_after_retire", imem_req_addr, npc);
        if (npc[1:0] == 2'b00) begin
            addr_q.push_back(npc);
            chk("next_req_valid", 32'(imem_req_valid), 32'(!stall_fetch));
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_addr", imem_req_addr, RESET_PC);
        chk("rst_req_valid", 32'(imem_req_valid), 32'(!stall_fetch));
        @(negedge clk);
        rst = 1'b0;
        inst_sb.delete();
        addr_q.delete();
        addr_q.push_back(RESET_PC);
        exp_retired = 32'd0;
    endtask

    logic [31:0] t;

    initial begin
        rst             = 1'b1;
        next_pc         = 32'd0;
        stall_fetch     = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        inst_ready      = 1'b0;
        exp_retired     = 32'd0;
        addr_q.push_back(RESET_PC);
        repeat (2) @(negedge clk);
        chk("por_inst", inst, NOP);
        chk("por_addr", imem_req_addr, RESET_PC);
        rst = 1'b0;
        @(negedge clk);

        // First fetch, best case
        fetch(0, 0, 0, 32'h0050_0093, pc_model(0, 32'h0, 32'h0, 32'h0));
        // Backpressure, then jump to 0x80
        fetch(2, 3, 1, 32'h07C0_006F, pc_model(1, 32'h4, 32'h0, 32'h7C));
        // JAL at 0x80, imm 0x100
        fetch(0, 1, 0, 32'h1000_006F, pc_model(1, 32'h80, 32'h0, 32'h100));
        chk("jal_target", imem_req_addr, 32'h180);
        // JALR rs1=0x2000 imm=-16
        fetch(1, 0, 2, 32'hFF00_8067, pc_model(2, 32'h180, 32'h2000, 32'hFFFF_FFF0));
        chk("jalr_target", imem_req_addr, 32'h1FF0);
        // JALR to the top of the address space
        fetch(0, 0, 0, 32'h00C0_8067, pc_model(2, 32'h1FF0, 32'hFFFF_FFF0, 32'hC));
        // Sequential at 0xFFFFFFFC wraps to 0
        fetch(0, 0, 0, 32'h0000_0013, pc_model(0, 32'hFFFF_FFFC, 32'h0, 32'h0));
        chk("wrap_addr", imem_req_addr, 32'h0);
        chk("wrap_fault", 32'(fault), 32'd0);

        // Stall in REQ for 4 cycles; ready high must be ignored
        stall_fetch    = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
            chk("stall_addr", imem_req_addr, 32'h0);
            @(negedge clk);
        end
        imem_req_ready = 1'b0;
        stall_fetch    = 1'b0;
        fetch(0, 0, 0, 32'h0010_0113, 32'h4);

        // Misaligned target -> sticky fault
        fetch(0, 0, 0, 32'h0020_0193, 32'h1002);
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        inst_ready      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fault", 32'(fault), 32'd1);
            chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
            chk("fault_inst_valid", 32'(inst_valid), 32'd0);
            chk("fault_pc", imem_req_addr, 32'h1002);
            @(negedge clk);
        end
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        t = retired;
        chk("fault_retired", t, exp_retired);
        do_reset();
        chk("post_fault_fault", 32'(fault), 32'd0);

        // Reset in the middle of WAIT, late response must be dropped
        #1;
        chk("mw_req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("mw_in_wait", 32'(imem_req_valid), 32'd0);
        do_reset();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        chk("stale_resp_valid", 32'(inst_valid), 32'd0);
        chk("stale_resp_inst", inst, NOP);
        fetch(0, 2, 0, 32'h00A0_0513, 32'h4);
        fetch(1, 0, 0, 32'h00B0_0593, 32'h8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
